hcsr04_varredura: RTL

Parametrised multi-channel HC-SR04 ranging controller. It is the successor to the single-sensor measurement path and sits between the top-level `medir` edge detector and the serial/display logic. On one `medir` pulse it scans CANAIS ultrasonic sensors in round-robin order. For each channel it generates the trigger, times the echo, converts the echo width to 3-digit BCD centimetres with saturation and timeout, and presents each result with a one-cycle `pronto` strobe.

---
 rtl/hcsr04_varredura.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hcsr04_varredura.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hcsr04_varredura: round-robin multi-channel HC-SR04 ranging controller.  |
// | Optional macro HCSR04_MASCARA_EN adds a per-scan channel enable mask.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hcsr04_varredura #(
    parameter int CANAIS         = 4,
    parameter int TRIGGER_CICLOS = 500,
    parameter int CICLOS_POR_CM  = 2941,
    parameter int TIMEOUT_CICLOS = 1500000,
    parameter int GUARDA_CICLOS  = 3000000,
    localparam int WC            = (CANAIS > 1) ? $clog2(CANAIS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              medir,
`ifdef HCSR04_MASCARA_EN
    input  logic [CANAIS-1:0] mascara,
`endif
    input  logic [CANAIS-1:0] echo,
    output logic [CANAIS-1:0] trigger,
    output logic [11:0]       medida,
    output logic [WC-1:0]     canal,
    output logic              timeout,
    output logic              pronto,
    output logic              fim_varredura,
    output logic              ocupado,
    output logic [3:0]        db_estado
);

    localparam logic [2:0] INICIAL  = 3'd0;
    localparam logic [2:0] TRIG     = 3'd1;
    localparam logic [2:0] ESPERA   = 3'd2;
    localparam logic [2:0] MEDE     = 3'd3;
    localparam logic [2:0] ARMAZENA = 3'd4;
    localparam logic [2:0] GUARDA   = 3'd5;

    localparam int CNT_MAX = (GUARDA_CICLOS > TRIGGER_CICLOS) ? GUARDA_CICLOS : TRIGGER_CICLOS;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CICLOS + 1);
    localparam int PW      = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;

    logic [2:0]        state;
    logic [2:0]        next;
    logic [CANAIS-1:0] echo_s1;
    logic [CANAIS-1:0] echo_s2;
    logic              echo_r;
    logic              echo_sel;
    logic              rise;
    logic              tout;
    logic              accept;
    logic [WC-1:0]     idx;
    logic [WC-1:0]     first_idx;
    logic [WC-1:0]     next_idx;
    logic              has_next;
    logic [CNTW-1:0]   cnt;
    logic [TW-1:0]     tcnt;
    logic [PW-1:0]     cyc;
    logic [11:0]       bcd;
    logic [CANAIS-1:0] start_mask;
    logic [CANAIS-1:0] scan_mask;

`ifdef HCSR04_MASCARA_EN
    logic [CANAIS-1:0] mask_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            mask_r <= '0;
        else if (accept)
            mask_r <= mascara;
    end

    assign start_mask = mascara;
    assign scan_mask  = mask_r;
`else
    assign start_mask = '1;
    assign scan_mask  = '1;
`endif

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign echo_sel = echo_s2[idx];
    // echo_r lags echo_sel by one cycle, so a rise needs a low-to-high change seen after entry
    assign rise     = echo_sel && !echo_r;
    assign tout     = ((state == ESPERA) || (state == MEDE)) && (tcnt == TW'(TIMEOUT_CICLOS - 1));
    assign accept   = (state == INICIAL) && medir && (|start_mask);

    always_comb begin
        first_idx = '0;
        next_idx  = idx;
        has_next  = 1'b0;
        for (int i = CANAIS - 1; i >= 0; i--) begin
            if (start_mask[i])
                first_idx = WC'(i);
            if (scan_mask[i] && (i > int'(idx))) begin
                next_idx = WC'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= INICIAL;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            INICIAL:  if (accept) next = TRIG;
            TRIG:     if (cnt == CNTW'(TRIGGER_CICLOS - 1)) next = ESPERA;
            ESPERA:   if (tout) next = ARMAZENA; else if (rise) next = MEDE;
            MEDE:     if (tout || !echo_r) next = ARMAZENA;
            ARMAZENA: next = GUARDA;
            GUARDA:   if (cnt == CNTW'(GUARDA_CICLOS - 1)) next = has_next ? TRIG : INICIAL;
            default:  next = INICIAL;
        endcase
    end

    always_comb begin
        trigger = '0;
        if (state == TRIG)
            trigger[idx] = 1'b1;
        pronto        = (state == ARMAZENA);
        fim_varredura = (state == ARMAZENA) && !has_next;
        ocupado       = (state != INICIAL);
        db_estado     = {1'b0, state};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_r  <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            tcnt    <= '0;
            cyc     <= '0;
            bcd     <= '0;
            medida  <= '0;
            canal   <= '0;
            timeout <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_r  <= echo_sel;

            if ((next != state) || !((state == TRIG) || (state == GUARDA)))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (accept)
                idx <= first_idx;
            else if ((state == GUARDA) && (next == TRIG))
                idx <= next_idx;

            if (state == TRIG) begin
                tcnt <= '0;
                cyc  <= '0;
                bcd  <= '0;
            end else begin
                if ((state == ESPERA) || (state == MEDE))
                    tcnt <= tcnt + 1'b1;
                // each full centimetre of echo-high time advances the decimal count
                if ((state == MEDE) && echo_r) begin
                    if (cyc == PW'(CICLOS_POR_CM - 1)) begin
                        cyc <= '0;
                        bcd <= bcd_inc(bcd);
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
            end

            if ((next == ARMAZENA) && (state != ARMAZENA)) begin
                medida  <= tout ? 12'h999 : bcd;
                timeout <= tout;
                canal   <= idx;
            end
        end
    end

endmodule
`default_nettype wire
